// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced run/pause/lap/clear FSM driving an MM:SS.CC BCD count.
// Timebases arrive as free-running square waves and are edge-detected locally.
`timescale 1ns / 1ps
module stopwatch_ctrl #(
    parameter int unsigned MAX_MIN   = 59,
    parameter int unsigned DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       f100Hz,
    input  logic       f,
    input  logic       key_ss_n,
    input  logic       key_lc_n,
    output logic       run,
    output logic       lapped,
    output logic       overflow,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd
);

    localparam logic [3:0] MinTens  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MinUnits = 4'(MAX_MIN % 10);
    localparam logic [7:0] DebTicks = 8'(DEB_TICKS);

    typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

    state_e      state_q, state_d;
    logic        run_q, run_d, lapped_q, lapped_d;
    logic [2:0]  f100_sync_q, f1k_sync_q;
    logic [1:0]  ss_sync_q, lc_sync_q;
    logic        ss_lvl_q, ss_lvl_d, lc_lvl_q, lc_lvl_d;
    logic [7:0]  ss_cnt_q, ss_cnt_d, lc_cnt_q, lc_cnt_d;
    logic [23:0] live_q, live_d, lap_q, lap_d;
    logic        overflow_q, overflow_d;

    logic        tick100, tick1k, ss_press, lc_press, ss_ev, lc_ev;
    logic [3:0]  c_u, c_t, s_u, s_t, m_u, m_t;

    assign tick100 = f100_sync_q[1] & ~f100_sync_q[2];
    assign tick1k  = f1k_sync_q[1] & ~f1k_sync_q[2];

    // Debounce: a differing level must persist across DEB_TICKS 1 kHz samples.
    always_comb begin
        ss_lvl_d = ss_lvl_q;
        ss_cnt_d = ss_cnt_q;
        ss_press = 1'b0;
        lc_lvl_d = lc_lvl_q;
        lc_cnt_d = lc_cnt_q;
        lc_press = 1'b0;
        if (tick1k) begin
            if (ss_sync_q[1] == ss_lvl_q) begin
                ss_cnt_d = '0;
            end else if (ss_cnt_q + 8'd1 >= DebTicks) begin
                ss_lvl_d = ss_sync_q[1];
                ss_cnt_d = '0;
                ss_press = ss_lvl_q;
            end else begin
                ss_cnt_d = ss_cnt_q + 8'd1;
            end
            if (lc_sync_q[1] == lc_lvl_q) begin
                lc_cnt_d = '0;
            end else if (lc_cnt_q + 8'd1 >= DebTicks) begin
                lc_lvl_d = lc_sync_q[1];
                lc_cnt_d = '0;
                lc_press = lc_lvl_q;
            end else begin
                lc_cnt_d = lc_cnt_q + 8'd1;
            end
        end
    end

    assign ss_ev = ss_press;
    assign lc_ev = lc_press & ~ss_press;

    always_comb begin
        state_d    = state_q;
        lap_d      = lap_q;
        overflow_d = overflow_q;
        {m_t, m_u, s_t, s_u, c_t, c_u} = live_q;

        if (tick100 && (state_q == StRun || state_q == StLap)) begin
            if (c_u != 4'd9) begin
                c_u = c_u + 4'd1;
            end else begin
                c_u = '0;
                if (c_t != 4'd9) begin
                    c_t = c_t + 4'd1;
                end else begin
                    c_t = '0;
                    if (s_u != 4'd9) begin
                        s_u = s_u + 4'd1;
                    end else begin
                        s_u = '0;
                        if (s_t != 4'd5) begin
                            s_t = s_t + 4'd1;
                        end else begin
                            s_t = '0;
                            if (m_t == MinTens && m_u == MinUnits) begin
                                m_t        = '0;
                                m_u        = '0;
                                overflow_d = 1'b1;
                            end else if (m_u != 4'd9) begin
                                m_u = m_u + 4'd1;
                            end else begin
                                m_u = '0;
                                m_t = m_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end
        live_d = {m_t, m_u, s_t, s_u, c_t, c_u};

        unique case (state_q)
            StIdle: if (ss_ev) state_d = StRun;
            StRun: begin
                if (ss_ev) begin
                    state_d = StPause;
                end else if (lc_ev) begin
                    state_d = StLap;
                    lap_d   = live_q;
                end
            end
            StLap: begin
                if (ss_ev) state_d = StPause;
                else if (lc_ev) state_d = StRun;
            end
            StPause: begin
                if (ss_ev) begin
                    state_d = StRun;
                end else if (lc_ev) begin
                    state_d    = StIdle;
                    live_d     = '0;
                    lap_d      = '0;
                    overflow_d = 1'b0;
                end
            end
        endcase

        run_d    = (state_d == StRun) || (state_d == StLap);
        lapped_d = (state_d == StLap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            lapped_q    <= 1'b0;
            f100_sync_q <= '0;
            f1k_sync_q  <= '0;
            ss_sync_q   <= '0;
            lc_sync_q   <= '0;
            ss_lvl_q    <= 1'b1;
            lc_lvl_q    <= 1'b1;
            ss_cnt_q    <= '0;
            lc_cnt_q    <= '0;
            live_q      <= '0;
            lap_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            lapped_q    <= lapped_d;
            f100_sync_q <= {f100_sync_q[1:0], f100Hz};
            f1k_sync_q  <= {f1k_sync_q[1:0], f};
            ss_sync_q   <= {ss_sync_q[0], key_ss_n};
            lc_sync_q   <= {lc_sync_q[0], key_lc_n};
            ss_lvl_q    <= ss_lvl_d;
            lc_lvl_q    <= lc_lvl_d;
            ss_cnt_q    <= ss_cnt_d;
            lc_cnt_q    <= lc_cnt_d;
            live_q      <= live_d;
            lap_q       <= lap_d;
            overflow_q  <= overflow_d;
        end
    end

    assign run      = run_q;
    assign lapped   = lapped_q;
    assign overflow = overflow_q;
    assign {min_bcd, sec_bcd, cs_bcd} = lapped_q ? lap_q : live_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected outputs, a monitor compares them.
`timescale 1ns / 1ps
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       f100Hz = 1'b0;
    logic       f = 1'b0;
    logic       key_ss_n = 1'b1;
    logic       key_lc_n = 1'b1;
    logic       run, lapped, overflow;
    logic [7:0] cs_bcd, sec_bcd, min_bcd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [26:0] val;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;

    stopwatch_ctrl #(
        .MAX_MIN  (2),
        .DEB_TICKS(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f100Hz  (f100Hz),
        .f       (f),
        .key_ss_n(key_ss_n),
        .key_lc_n(key_lc_n),
        .run     (run),
        .lapped  (lapped),
        .overflow(overflow),
        .cs_bcd  (cs_bcd),
        .sec_bcd (sec_bcd),
        .min_bcd (min_bcd)
    );

    always #5 clk = ~clk;

    initial begin
        exp_t        e;
        logic [26:0] act;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {run, lapped, overflow, min_bcd, sec_bcd, cs_bcd};
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got run=%b lapped=%b ovf=%b %h:%h.%h, want run=%b lapped=%b ovf=%b %h:%h.%h",
                             e.name, act[26], act[25], act[24], act[23:16], act[15:8], act[7:0],
                             e.val[26], e.val[25], e.val[24], e.val[23:16], e.val[15:8], e.val[7:0]);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic r, input logic l, input logic o,
                              input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] cs);
        exp_t e;
        e.name = name;
        e.val  = {r, l, o, mn, sc, cs};
        sb_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    // Each pulse: 2 clk high, 2 clk low; the count settles before the task returns.
    task automatic pulse(input int n, input bit do100, input bit do1k);
        repeat (n) begin
            @(negedge clk);
            if (do100) f100Hz = 1'b1;
            if (do1k) f = 1'b1;
            @(negedge clk);
            @(negedge clk);
            f100Hz = 1'b0;
            f      = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input bit ss, input bit lc);
        @(negedge clk);
        if (ss) key_ss_n = 1'b0;
        if (lc) key_lc_n = 1'b0;
        pulse(3, 1'b0, 1'b1);
        key_ss_n = 1'b1;
        key_lc_n = 1'b1;
        pulse(3, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        expect_out("reset_state", 0, 0, 0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        press(1, 0);
        pulse(37, 1, 0);
        expect_out("run_37", 1, 0, 0, 8'h00, 8'h00, 8'h37);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 0, 0, 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(10, 1, 0);
        expect_out("idle_no_count", 0, 0, 0, 8'h00, 8'h00, 8'h00);

        press(1, 0);
        expect_out("ss_start", 1, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL ss_start_run: got run=%b, want 1", run);
        end
        pulse(150, 1, 0);
        expect_out("count_150", 1, 0, 0, 8'h00, 8'h01, 8'h50);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_ss_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            pulse(1, 0, 1);
        end
        @(negedge clk);
        key_ss_n = 1'b0;
        pulse(3, 0, 1);
        key_ss_n = 1'b1;
        pulse(3, 0, 1);
        expect_out("bounce_one_event", 0, 0, 0, 8'h00, 8'h01, 8'h50);
        pulse(5, 1, 0);
        expect_out("pause_holds", 0, 0, 0, 8'h00, 8'h01, 8'h50);

        press(1, 0);
        pulse(1084, 1, 0);
        expect_out("count_1234", 1, 0, 0, 8'h00, 8'h12, 8'h34);
        press(0, 1);
        expect_out("lap_enter", 1, 1, 0, 8'h00, 8'h12, 8'h34);
        checks++;
        if (lapped !== 1'b1) begin
            errors++;
            $display("FAIL lap_enter_lapped: got lapped=%b, want 1", lapped);
        end
        pulse(100, 1, 0);
        expect_out("lap_frozen", 1, 1, 0, 8'h00, 8'h12, 8'h34);
        press(0, 1);
        expect_out("lap_exit_live", 1, 0, 0, 8'h00, 8'h13, 8'h34);

        // Both keys accepted on the same clk as a 100 Hz tick.
        @(negedge clk);
        key_ss_n = 1'b0;
        key_lc_n = 1'b0;
        pulse(1, 0, 1);
        pulse(1, 1, 1);
        key_ss_n = 1'b1;
        key_lc_n = 1'b1;
        pulse(3, 0, 1);
        expect_out("ss_wins_tick_counted", 0, 0, 0, 8'h00, 8'h13, 8'h35);

        press(1, 0);
        pulse(16664, 1, 0);
        expect_out("at_max", 1, 0, 0, 8'h02, 8'h59, 8'h99);
        pulse(1, 1, 0);
        expect_out("wrap_overflow", 1, 0, 1, 8'h00, 8'h00, 8'h00);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_overflow_flag: got overflow=%b, want 1", overflow);
        end
        press(1, 0);
        expect_out("pause_keeps_ovf", 0, 0, 1, 8'h00, 8'h00, 8'h00);
        press(0, 1);
        expect_out("clear_to_idle", 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow_flag: got overflow=%b, want 0", overflow);
        end
        press(0, 1);
        expect_out("idle_lc_ignored", 0, 0, 0, 8'h00, 8'h00, 8'h00);
        press(1, 0);
        expect_out("idle_ss_run", 1, 0, 0, 8'h00, 8'h00, 8'h00);

        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
